// File: rtl/qpp_interleaver_ctrl.sv
// qpp_interleaver_ctrl
// Buffers one block of K samples written in natural order and streams them
// back out in QPP-permuted order: out[j] = in[pi(j)], pi(j) = (F1*j + F2*j^2) mod K.
// The permuted address is generated by a second-order recursion that only
// needs add + conditional-subtract, so no multiplier or divider is required.
//
// Handshake semantics (both sides): a beat transfers on a rising clock edge
// where valid && ready are both high. The producer keeps valid and data stable
// until the transfer happens; ready may change freely. in_valid is ignored
// whenever in_ready is low, and out_valid never drops without a transfer.
module qpp_interleaver_ctrl #(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned MAX_K  = 6144,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_k,
    input  logic [ADDR_W-1:0] cfg_f1,
    input  logic [ADDR_W-1:0] cfg_f2,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] MAX_K_C = ADDR_W'(MAX_K);
    localparam logic [ADDR_W-1:0] MIN_K_C = ADDR_W'(40);

    // Reduce a value known to be < 2*m into [0, m) with one compare-subtract.
    function automatic logic [ADDR_W-1:0] mod_once(input logic [ADDR_W:0]   a,
                                                  input logic [ADDR_W-1:0] m);
        logic [ADDR_W:0] m_ext;
        logic [ADDR_W:0] diff;
        m_ext = {1'b0, m};
        diff  = a - m_ext;
        if (a >= m_ext) begin
            return diff[ADDR_W-1:0];
        end
        return a[ADDR_W-1:0];
    endfunction

    // Sample buffer: written in natural order, read in permuted order.
    logic [DATA_W-1:0] mem [MAX_K];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;          // latched block size
    logic [ADDR_W-1:0] f2x2_q, f2x2_d;    // (2*F2) mod K, second difference of pi
    logic [ADDR_W-1:0] pi_q, pi_d;        // address of the next read to issue
    logic [ADDR_W-1:0] g_q, g_d;          // first difference pi(j+1)-pi(j) mod K
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;    // write beats accepted
    logic [ADDR_W-1:0] icnt_q, icnt_d;    // buffer reads issued
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] out_data_q;

    logic              wr_en;
    logic              rd_en;
    logic              cfg_ok;
    logic              out_hs;
    logic              last_wr;
    logic              all_issued;
    logic [ADDR_W-1:0] pi_next;
    logic [ADDR_W-1:0] g_next;
    logic [ADDR_W-1:0] g_init;
    logic [ADDR_W-1:0] f2x2_init;

    // Config legality and the arithmetic feeding the address recursion.
    always_comb begin
        cfg_ok = (cfg_k >= MIN_K_C) && (cfg_k <= MAX_K_C) &&
                 (cfg_k[2:0] == 3'b000) &&
                 (cfg_f1 < cfg_k) && (cfg_f2 < cfg_k);
        // Operands are all < K, so each sum is < 2K and one subtract suffices.
        g_init     = mod_once({1'b0, cfg_f1} + {1'b0, cfg_f2}, cfg_k);
        f2x2_init  = mod_once({cfg_f2, 1'b0}, cfg_k);
        pi_next    = mod_once({1'b0, pi_q} + {1'b0, g_q}, k_q);
        g_next     = mod_once({1'b0, g_q} + {1'b0, f2x2_q}, k_q);
        last_wr    = (wcnt_q == (k_q - ADDR_W'(1)));
        all_issued = (icnt_q == k_q);
        out_hs     = out_valid_q && out_ready;
    end

    // Next-state and datapath control for the IDLE/WRITE/READ/DONE sequence.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        f2x2_d      = f2x2_q;
        pi_d        = pi_q;
        g_d         = g_q;
        wcnt_d      = wcnt_q;
        icnt_d      = icnt_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        k_d     = cfg_k;
                        f2x2_d  = f2x2_init;
                        pi_d    = '0;
                        g_d     = g_init;
                        wcnt_d  = '0;
                        icnt_d  = '0;
                        state_d = ST_WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                if (in_valid) begin
                    wr_en  = 1'b1;
                    wcnt_d = wcnt_q + ADDR_W'(1);
                    if (last_wr) begin
                        state_d = ST_READ;
                    end
                end
            end

            ST_READ: begin
                // out_data holds sample icnt-1; once icnt==K the beat on the
                // port is the final one, so its transfer ends the block.
                if (out_hs && all_issued) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_DONE;
                end else if ((!out_valid_q || out_ready) && !all_issued) begin
                    rd_en       = 1'b1;
                    pi_d        = pi_next;
                    g_d         = g_next;
                    icnt_d      = icnt_q + ADDR_W'(1);
                    out_valid_d = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and counter registers; reset aborts any block in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            f2x2_q      <= '0;
            pi_q        <= '0;
            g_q         <= '0;
            wcnt_q      <= '0;
            icnt_q      <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            f2x2_q      <= f2x2_d;
            pi_q        <= pi_d;
            g_q         <= g_d;
            wcnt_q      <= wcnt_d;
            icnt_q      <= icnt_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    // Buffer write port; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wcnt_q] <= in_data;
        end
    end

    // Synchronous buffer read straight into the output register; holding
    // rd_en low during a stall keeps out_data stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q <= '0;
        end else if (rd_en) begin
            out_data_q <= mem[pi_q];
        end
    end

    assign in_ready  = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_qpp_interleaver_ctrl.sv
// Testbench for qpp_interleaver_ctrl: random data and backpressure, expected
// output order computed directly from pi(j) = (F1*j + F2*j^2) mod K.
module tb_qpp_interleaver_ctrl;

    localparam int DATA_W = 13;
    localparam int MAX_K  = 6144;
    localparam int ADDR_W = 13;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              start;
    logic [ADDR_W-1:0] cfg_k, cfg_f1, cfg_f2;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              busy, done, err;
    logic [1:0]        dbg_state;

    qpp_interleaver_ctrl #(
        .DATA_W (DATA_W),
        .MAX_K  (MAX_K),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_k     (cfg_k),
        .cfg_f1    (cfg_f1),
        .cfg_f2    (cfg_f2),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int                n_pass  = 0;
    int                n_total = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    int                popped;
    bit                rdy_random;
    logic              have_prev;
    logic [DATA_W-1:0] prev_data;
    logic [DATA_W-1:0] exp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference permutation straight from the closed form.
    function automatic int qpp(input int j, input int k, input int f1, input int f2);
        longint jj;
        jj = longint'(j);
        return int'((longint'(f1) * jj + longint'(f2) * jj * jj) % longint'(k));
    endfunction

    // ---------------- downstream ready driver ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor: pops and compares on every output transfer ----------------
    always @(negedge clk) begin
        if (reset) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: got %0d, expected no beat", out_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("out_data", out_data, exp_e);
                end
                got_q.push_back(out_data);
                popped++;
            end
            have_prev = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_err"},       err,       0);
        check({tag, "_state"},     dbg_state, 0);
    endtask

    task automatic run_block(input int k, input int f1, input int f2,
                             input bit ramp, input bit gaps, input int abort_at);
        logic [DATA_W-1:0] din[];
        bit seen_done;
        din = new[k];
        for (int i = 0; i < k; i++)
            din[i] = ramp ? DATA_W'(i) : DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
        for (int j = 0; j < k; j++)
            exp_q.push_back(din[qpp(j, k, f1, f2)]);
        got_q.delete();
        popped = 0;

        start    = 1'b1;
        cfg_k    = ADDR_W'(k);
        cfg_f1   = ADDR_W'(f1);
        cfg_f2   = ADDR_W'(f2);
        in_valid = 1'b1;  // must be ignored outside WRITE
        in_data  = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
        @(posedge clk);
        #1;
        start  = 1'b0;
        cfg_k  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
        cfg_f1 = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
        cfg_f2 = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
        in_valid = 1'b0;
        check("start_busy", busy, 1);
        check("start_in_ready", in_ready, 1);
        check("start_no_err", err, 0);

        for (int i = 0; i < k; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    start    = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = din[i];
            start    = (i == 5);  // start while busy must be ignored
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("in_ready_drop", in_ready, 0);
        check("latency_cycle1_no_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("latency_cycle2_valid", out_valid, 1);

        seen_done = 1'b0;
        for (int c = 0; c < 8 * k + 50; c++) begin
            if (abort_at >= 0 && popped >= abort_at) begin
                reset = 1'b1;
                #1;
                check_idle_outputs("abort");
                exp_q.delete();
                @(posedge clk);
                #1;
                reset = 1'b0;
                return;
            end
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end

        if (!seen_done) begin
            check("done_seen", done, 1);
            reset = 1'b1;
            exp_q.delete();
            @(posedge clk);
            #1;
            reset = 1'b0;
            return;
        end
        check("queue_drained", exp_q.size(), 0);
        check("beats_out", popped, k);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("idle_after_done", dbg_state, 0);
    endtask

    task automatic illegal_start(input int k, input int f1, input int f2);
        start  = 1'b1;
        cfg_k  = ADDR_W'(k);
        cfg_f1 = ADDR_W'(f1);
        cfg_f2 = ADDR_W'(f2);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("illegal_err_pulse", err, 1);
        check("illegal_in_ready", in_ready, 0);
        check("illegal_busy", busy, 0);
        @(posedge clk);
        #1;
        check("illegal_err_one_cycle", err, 0);
        check("illegal_still_idle", busy, 0);
    endtask

    // ---------------- global watchdog ----------------
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k, f1, f2, distinct;
        bit seen[];
        int ill_k[5]  = '{44, 36, 6152, 48, 48};
        int ill_f1[5] = '{1, 0, 1, 48, 0};
        int ill_f2[5] = '{1, 0, 1, 0, 50};

        reset = 1'b1;
        start = 1'b0;
        cfg_k = '0;
        cfg_f1 = '0;
        cfg_f2 = '0;
        in_valid = 1'b0;
        in_data = '0;
        rdy_random = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("post_reset");

        // Smallest block, ramp data: out = pi(j) directly.
        run_block(40, 3, 10, 1'b1, 1'b0, -1);
        check("t1_beat1", got_q[1], 13);
        check("t1_beat2", got_q[2], 6);
        check("t1_beat3", got_q[3], 19);

        // Largest block.
        run_block(6144, 263, 480, 1'b1, 1'b0, -1);
        check("t2_beat1", got_q[1], 743);
        seen = new[6144];
        distinct = 0;
        foreach (got_q[i]) begin
            if (got_q[i] < 6144 && !seen[got_q[i]]) begin
                seen[got_q[i]] = 1'b1;
                distinct++;
            end
        end
        check("t2_permutation", distinct, 6144);

        // Random backpressure and input gaps.
        rdy_random = 1'b1;
        run_block(40, 3, 10, 1'b1, 1'b1, -1);
        check("t3_beat1", got_q[1], 13);

        // Illegal configurations.
        rdy_random = 1'b0;
        for (int i = 0; i < 5; i++) illegal_start(ill_k[i], ill_f1[i], ill_f2[i]);

        // Reset mid-READ, then a clean block.
        rdy_random = 1'b1;
        run_block(40, 3, 10, 1'b0, 1'b1, 20);
        check_idle_outputs("after_abort");
        run_block(40, $urandom_range(0, 39), $urandom_range(0, 39), 1'b0, 1'b0, -1);

        // Back-to-back blocks with different K.
        rdy_random = 1'b0;
        run_block(48, 7, 12, 1'b0, 1'b0, -1);
        run_block(40, 3, 10, 1'b0, 1'b0, -1);
        rdy_random = 1'b1;
        for (int n = 0; n < 3; n++) begin
            k  = 8 * $urandom_range(5, 32);
            f1 = $urandom_range(0, k - 1);
            f2 = $urandom_range(0, k - 1);
            run_block(k, f1, f2, 1'b0, 1'b1, -1);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
